// File: rtl/ps_pkg.sv
// Shared program-sequencer definitions: ureg address map and LIFO operation codes.
package ps_pkg;

  localparam logic [4:0] UREG_PCSTK  = 5'b00100;
  localparam logic [4:0] UREG_PCSTKP = 5'b00101;

  typedef enum logic [1:0] {
    LIFO_IDLE,
    LIFO_PUSH,
    LIFO_POP,
    LIFO_REPL
  } lifo_op_e;

endpackage

// File: rtl/ps_lifo.sv
// Parameterised LIFO storage with entry-count pointer and full/empty flags.
module ps_lifo
  import ps_pkg::*;
#(
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  lifo_op_e         op_i,
  input  logic [W-1:0]     data_i,
  output logic [W-1:0]     top_o,
  output logic [PTR_W-1:0] ptr_o,
  output logic             empty_o,
  output logic             full_o
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    top_idx;

  assign top_idx = AW'(ptr_q - PTR_W'(1));
  assign empty_o = (ptr_q == '0);
  assign full_o  = (ptr_q == PTR_W'(DEPTH));
  assign ptr_o   = ptr_q;
  assign top_o   = empty_o ? '0 : mem_q[top_idx];

  always_comb begin
    ptr_d  = ptr_q;
    wr_en  = 1'b0;
    wr_idx = AW'(ptr_q);
    unique case (op_i)
      LIFO_PUSH: begin
        if (!full_o) begin
          wr_en = 1'b1;
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      LIFO_POP: begin
        if (!empty_o) ptr_d = ptr_q - PTR_W'(1);
      end
      LIFO_REPL: begin
        if (!empty_o) begin
          wr_en  = 1'b1;
          wr_idx = top_idx;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

  // Storage is deliberately not reset; only the write is suppressed during reset.
  always_ff @(posedge clk_i) begin
    if (wr_en && !rst_i) mem_q[wr_idx] <= data_i;
  end

endmodule

// File: rtl/ps_pcstk.sv
// Program-sequencer PC stack: push/pop arbitration, sticky ovf/unf and ureg read mux.
module ps_pcstk
  import ps_pkg::*;
#(
  parameter int unsigned PC_W  = 16,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ps_wrt_en,
  input  logic [4:0]       ps_wrt_add,
  input  logic [PC_W-1:0]  ps_bus_wrt_dt,
  input  logic [4:0]       ps_rd_add,
  input  logic             ps_popstck,
  input  logic             ps_call,
  input  logic [PC_W-1:0]  ps_call_rtn_pc,
  input  logic             ps_rts,
  input  logic             ps_stkyclr,
  output logic [PC_W-1:0]  ps_pcstk_rd_dt,
  output logic [PC_W-1:0]  ps_rts_pc,
  output logic [PTR_W-1:0] ps_pcstk_ptr,
  output logic             ps_pcstk_empty,
  output logic             ps_pcstk_full,
  output logic             ps_pcstk_ovf,
  output logic             ps_pcstk_unf
);

  logic            psh, pop;
  logic [PC_W-1:0] psh_dt;
  lifo_op_e        op;
  logic            ovf_q, ovf_d, unf_q, unf_d;
  logic            ovf_set, unf_set;

  assign psh    = ps_call | (ps_wrt_en & (ps_wrt_add == UREG_PCSTK));
  assign pop    = ps_popstck | ps_rts;
  assign psh_dt = ps_call ? ps_call_rtn_pc : ps_bus_wrt_dt;

  // Push+pop on an empty stack degrades to a plain push.
  always_comb begin
    op = LIFO_IDLE;
    if (psh && pop) op = ps_pcstk_empty ? LIFO_PUSH : LIFO_REPL;
    else if (psh)   op = LIFO_PUSH;
    else if (pop)   op = LIFO_POP;
  end

  ps_lifo #(
    .W     (PC_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) u_lifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .op_i    (op),
    .data_i  (psh_dt),
    .top_o   (ps_rts_pc),
    .ptr_o   (ps_pcstk_ptr),
    .empty_o (ps_pcstk_empty),
    .full_o  (ps_pcstk_full)
  );

  assign ovf_set = psh & ~pop & ps_pcstk_full;
  assign unf_set = pop & ~psh & ps_pcstk_empty;
  assign ovf_d   = (ovf_q & ~ps_stkyclr) | ovf_set;
  assign unf_d   = (unf_q & ~ps_stkyclr) | unf_set;

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign ps_pcstk_ovf = ovf_q;
  assign ps_pcstk_unf = unf_q;

  always_comb begin
    ps_pcstk_rd_dt = '0;
    unique case (ps_rd_add)
      UREG_PCSTK:  ps_pcstk_rd_dt = ps_rts_pc;
      UREG_PCSTKP: ps_pcstk_rd_dt = PC_W'(ps_pcstk_ptr);
      default:     ps_pcstk_rd_dt = '0;
    endcase
  end

endmodule

// File: tb/tb_ps_pcstk.sv
// Bench for ps_pcstk: queue-based reference model compared every cycle, plus directed literal checks.
module tb_ps_pcstk;

  localparam int PC_W  = 16;
  localparam int DEPTH = 8;
  localparam int PTR_W = $clog2(DEPTH + 1);

  logic             clk;
  logic             rst;
  logic             ps_wrt_en;
  logic [4:0]       ps_wrt_add;
  logic [PC_W-1:0]  ps_bus_wrt_dt;
  logic [4:0]       ps_rd_add;
  logic             ps_popstck;
  logic             ps_call;
  logic [PC_W-1:0]  ps_call_rtn_pc;
  logic             ps_rts;
  logic             ps_stkyclr;
  logic [PC_W-1:0]  ps_pcstk_rd_dt;
  logic [PC_W-1:0]  ps_rts_pc;
  logic [PTR_W-1:0] ps_pcstk_ptr;
  logic             ps_pcstk_empty;
  logic             ps_pcstk_full;
  logic             ps_pcstk_ovf;
  logic             ps_pcstk_unf;

  ps_pcstk #(
    .PC_W  (PC_W),
    .DEPTH (DEPTH),
    .PTR_W (PTR_W)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .ps_wrt_en      (ps_wrt_en),
    .ps_wrt_add     (ps_wrt_add),
    .ps_bus_wrt_dt  (ps_bus_wrt_dt),
    .ps_rd_add      (ps_rd_add),
    .ps_popstck     (ps_popstck),
    .ps_call        (ps_call),
    .ps_call_rtn_pc (ps_call_rtn_pc),
    .ps_rts         (ps_rts),
    .ps_stkyclr     (ps_stkyclr),
    .ps_pcstk_rd_dt (ps_pcstk_rd_dt),
    .ps_rts_pc      (ps_rts_pc),
    .ps_pcstk_ptr   (ps_pcstk_ptr),
    .ps_pcstk_empty (ps_pcstk_empty),
    .ps_pcstk_full  (ps_pcstk_full),
    .ps_pcstk_ovf   (ps_pcstk_ovf),
    .ps_pcstk_unf   (ps_pcstk_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  bit armed  = 1'b0;

  logic [PC_W-1:0] mq [$];
  bit m_ovf = 1'b0;
  bit m_unf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [PC_W-1:0] m_top();
    if (mq.size() == 0) return '0;
    return mq[mq.size() - 1];
  endfunction

  function automatic logic [PC_W-1:0] m_rd(input logic [4:0] a);
    if (a == 5'b00100) return m_top();
    if (a == 5'b00101) return PC_W'(mq.size());
    return '0;
  endfunction

  // Applies the stack rules to the inputs sampled at this edge.
  task automatic model_update();
    bit psh, pop, os, us;
    logic [PC_W-1:0] d;
    armed = 1'b1;
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      psh = ps_call || (ps_wrt_en && ps_wrt_add == 5'b00100);
      pop = ps_popstck || ps_rts;
      d   = ps_call ? ps_call_rtn_pc : ps_bus_wrt_dt;
      os  = 1'b0;
      us  = 1'b0;
      if (psh && pop && mq.size() > 0) mq[mq.size() - 1] = d;
      else if (psh) begin
        if (mq.size() < DEPTH) mq.push_back(d);
        else os = 1'b1;
      end else if (pop) begin
        if (mq.size() > 0) void'(mq.pop_back());
        else us = 1'b1;
      end
      if (ps_stkyclr) begin
        m_ovf = 1'b0;
        m_unf = 1'b0;
      end
      m_ovf = m_ovf | os;
      m_unf = m_unf | us;
    end
  endtask

  always @(negedge clk) begin
    if (armed) begin
      chk("ptr",   32'(ps_pcstk_ptr),   32'(mq.size()));
      chk("empty", 32'(ps_pcstk_empty), 32'(mq.size() == 0));
      chk("full",  32'(ps_pcstk_full),  32'(mq.size() == DEPTH));
      chk("ovf",   32'(ps_pcstk_ovf),   32'(m_ovf));
      chk("unf",   32'(ps_pcstk_unf),   32'(m_unf));
      chk("rts_pc", 32'(ps_rts_pc),     32'(m_top()));
      chk("rd_dt", 32'(ps_pcstk_rd_dt), 32'(m_rd(ps_rd_add)));
    end
  end

  task automatic idle();
    rst            = 1'b0;
    ps_wrt_en      = 1'b0;
    ps_wrt_add     = 5'd0;
    ps_bus_wrt_dt  = '0;
    ps_popstck     = 1'b0;
    ps_call        = 1'b0;
    ps_call_rtn_pc = '0;
    ps_rts         = 1'b0;
    ps_stkyclr     = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
    #1;
    idle();
  endtask

  task automatic do_call(input logic [PC_W-1:0] pc);
    ps_call = 1'b1; ps_call_rtn_pc = pc; step();
  endtask

  task automatic do_upush(input logic [PC_W-1:0] dt);
    ps_wrt_en = 1'b1; ps_wrt_add = 5'b00100; ps_bus_wrt_dt = dt; step();
  endtask

  initial begin
    idle();
    ps_rd_add = 5'b00101;
    rst = 1'b1;
    step();
    chk("rst_ptr_rd", 32'(ps_pcstk_rd_dt), 32'h0);
    chk("rst_empty",  32'(ps_pcstk_empty), 32'h1);
    ps_rd_add = 5'b00100;
    #1;
    chk("rst_top_rd", 32'(ps_pcstk_rd_dt), 32'h0);

    do_call(16'h0100);
    do_call(16'h0200);
    do_call(16'h0300);
    chk("call_ptr", 32'(ps_pcstk_ptr), 32'd3);
    chk("call_top", 32'(ps_rts_pc),    32'h0300);
    ps_rts = 1'b1; step();
    chk("rts1_top", 32'(ps_rts_pc), 32'h0200);
    ps_rts = 1'b1; step();
    chk("rts2_top", 32'(ps_rts_pc), 32'h0100);
    ps_rts = 1'b1; step();
    chk("rts3_empty", 32'(ps_pcstk_empty), 32'h1);

    for (int i = 1; i <= 9; i++) do_upush(PC_W'(i));
    chk("ovf_ptr",  32'(ps_pcstk_ptr),  32'd8);
    chk("ovf_full", 32'(ps_pcstk_full), 32'h1);
    chk("ovf_flag", 32'(ps_pcstk_ovf),  32'h1);
    chk("ovf_top",  32'(ps_rts_pc),     32'h0008);
    ps_stkyclr = 1'b1; step();
    chk("ovf_clr", 32'(ps_pcstk_ovf), 32'h0);
    for (int i = 0; i < DEPTH; i++) begin
      ps_popstck = 1'b1; step();
    end

    ps_popstck = 1'b1; step();
    chk("unf_ptr",  32'(ps_pcstk_ptr), 32'd0);
    chk("unf_flag", 32'(ps_pcstk_unf), 32'h1);
    ps_stkyclr = 1'b1; ps_popstck = 1'b1; step();
    chk("unf_setwins", 32'(ps_pcstk_unf), 32'h1);
    ps_stkyclr = 1'b1; step();
    chk("unf_clr", 32'(ps_pcstk_unf), 32'h0);

    do_call(16'h0AAA);
    ps_wrt_en = 1'b1; ps_wrt_add = 5'b00100; ps_bus_wrt_dt = 16'h0BBB; ps_popstck = 1'b1;
    step();
    chk("repl_ptr", 32'(ps_pcstk_ptr), 32'd1);
    chk("repl_top", 32'(ps_rts_pc),    32'h0BBB);

    ps_call = 1'b1; ps_call_rtn_pc = 16'h0111;
    ps_wrt_en = 1'b1; ps_wrt_add = 5'b00100; ps_bus_wrt_dt = 16'h0222;
    step();
    chk("arb_ptr", 32'(ps_pcstk_ptr), 32'd2);
    chk("arb_top", 32'(ps_rts_pc),    32'h0111);
    chk("arb_ovf", 32'(ps_pcstk_ovf), 32'h0);

    rst = 1'b1; ps_call = 1'b1; ps_call_rtn_pc = 16'h1234;
    step();
    chk("midrst_ptr", 32'(ps_pcstk_ptr), 32'd0);

    for (int blk = 0; blk < 6; blk++) begin
      for (int n = 0; n < 400; n++) begin
        bit push_bias;
        push_bias      = (blk % 2 == 0);
        ps_call        = ($urandom_range(0, 9) < (push_bias ? 4 : 1));
        ps_call_rtn_pc = PC_W'($urandom);
        ps_wrt_en      = ($urandom_range(0, 9) < (push_bias ? 5 : 2));
        ps_wrt_add     = ($urandom_range(0, 1) == 0) ? 5'b00100 : 5'($urandom);
        ps_bus_wrt_dt  = PC_W'($urandom);
        ps_popstck     = ($urandom_range(0, 9) < (push_bias ? 1 : 4));
        ps_rts         = ($urandom_range(0, 9) < (push_bias ? 1 : 3));
        ps_stkyclr     = ($urandom_range(0, 9) == 0);
        rst            = ($urandom_range(0, 149) == 0);
        case ($urandom_range(0, 2))
          0:       ps_rd_add = 5'b00100;
          1:       ps_rd_add = 5'b00101;
          default: ps_rd_add = 5'($urandom);
        endcase
        step();
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
